text_fetch_sched: RTL and testbench

Character-cell fetch scheduler for the 640x480 text display, clocked on the pixel clock. It splits the screen into 80x40 cells of 8x12 pixels and, for each cell, sequences the text-RAM read, the font-ROM read, row selection and shift-register load. It then serialises one monochrome Pixel per clock into pix_to_rgb. It also shares the single-port text RAM between display fetches and a host write port.

---
 rtl/text_fetch_sched.sv | 178 +++++++++++++++++
 tb/tb_text_fetch_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_fetch_sched.sv
// text_fetch_sched
//   Character-cell fetch scheduler for a 640x480 text display, clocked on the
//   pixel clock. The screen is split into COLS x ROWS cells of 8x12 pixels.
//   During each cell the block fetches the *next* cell: text RAM read, font ROM
//   read, glyph-row select, then a shift-register load at the last pixel of
//   the cell. One monochrome pixel per clock leaves on Pixel. The single-port
//   text RAM is shared with a host write port.
//
//   Optional feature macro: CHARGEN_CURSOR_EN (blinking underline cursor).
//
// Ports
//   clock25            pixel clock
//   reset              synchronous, active-high
//   HorizontalCounter  0..799, visible 0..639
//   VerticalCounter    0..524, visible 0..479
//   text_addr/we/wdata text RAM port (registered); cell index = row*COLS+col
//   text_rdata         text RAM read data (sync read)
//   font_addr          font ROM address = character code (registered)
//   font_data          font ROM glyph, row r at bits [95-8r -: 8], MSB leftmost
//   host_req/addr/data host write request, held until host_ack
//   host_ack           one-cycle acknowledge (registered)
//   cursor_addr        cursor cell index (CHARGEN_CURSOR_EN only)
//   Pixel              serialised pixel (registered)
module text_fetch_sched #(
    parameter int COLS = 80,
    parameter int ROWS = 40
) (
    input  logic        clock25,
    input  logic        reset,
    input  logic [9:0]  HorizontalCounter,
    input  logic [9:0]  VerticalCounter,
    output logic [11:0] text_addr,
    output logic        text_we,
    output logic [6:0]  text_wdata,
    input  logic [6:0]  text_rdata,
    output logic [6:0]  font_addr,
    input  logic [95:0] font_data,
    input  logic        host_req,
    input  logic [11:0] host_addr,
    input  logic [6:0]  host_data,
    output logic        host_ack,
`ifdef CHARGEN_CURSOR_EN
    input  logic [11:0] cursor_addr,
`endif
    output logic        Pixel
);

    localparam logic [11:0] COLS_W  = 12'(COLS);
    localparam logic [12:0] CELLS_W = 13'(COLS * ROWS);

    // Target cell (the one after the cell currently being displayed)
    logic [2:0]  phase;
    logic [6:0]  tgt_col;
    logic [9:0]  tgt_line;
    logic [11:0] tgt_row;
    logic [3:0]  glyph_row;
    logic [11:0] tgt_index;
    logic        tgt_valid;
    logic [6:0]  slice_sh;
    logic [7:0]  glyph_slice;
    logic [7:0]  glyph_mask;
    logic        grant;

    // State
    logic [11:0] text_addr_q,  text_addr_d;
    logic        text_we_q,    text_we_d;
    logic [6:0]  text_wdata_q, text_wdata_d;
    logic [6:0]  font_addr_q,  font_addr_d;
    logic        host_ack_q,   host_ack_d;
    logic        pixel_q,      pixel_d;
    logic [7:0]  shreg_q,      shreg_d;
    logic [7:0]  next_row_q,   next_row_d;
`ifdef CHARGEN_CURSOR_EN
    logic [5:0]  frame_cnt_q,  frame_cnt_d;
`endif

    always_comb begin
        phase = HorizontalCounter[2:0];
        // In the last cell slot of a line, fetch column 0 of the next line.
        if (HorizontalCounter >= 10'd792) begin
            tgt_col  = 7'd0;
            tgt_line = (VerticalCounter == 10'd524) ? 10'd0 : VerticalCounter + 10'd1;
        end else begin
            tgt_col  = HorizontalCounter[9:3] + 7'd1;
            tgt_line = VerticalCounter;
        end
        tgt_row   = 12'(tgt_line / 10'd12);
        glyph_row = 4'(tgt_line % 10'd12);
        tgt_index = tgt_row * COLS_W + {5'd0, tgt_col};
        tgt_valid = ({5'd0, tgt_col} < COLS_W) && (tgt_line < 10'd480);
        // Row r sits at bits [95-8r -: 8]: shift it down to [7:0].
        slice_sh    = 7'd88 - {glyph_row, 3'b000};
        glyph_slice = 8'(font_data >> slice_sh);
    end

`ifdef CHARGEN_CURSOR_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (HorizontalCounter == 10'd0 && VerticalCounter == 10'd0)
            frame_cnt_d = frame_cnt_q + 6'd1;
        glyph_mask = '0;
        if (frame_cnt_q[5] && tgt_index == cursor_addr && glyph_row >= 4'd10)
            glyph_mask = 8'hFF;
    end
`else
    assign glyph_mask = '0;
`endif

    always_comb begin
        text_addr_d  = text_addr_q;
        text_we_d    = 1'b0;
        text_wdata_d = text_wdata_q;
        font_addr_d  = font_addr_q;
        host_ack_d   = 1'b0;
        next_row_d   = next_row_q;
        pixel_d      = shreg_q[7];
        shreg_d      = {shreg_q[6:0], 1'b0};

        // Display owns p=0; the edge right after an ack is never granted, which
        // covers the host's de-assert latency.
        grant = host_req && (phase != 3'd0) && !host_ack_q;

        if (phase == 3'd0) begin
            text_addr_d = tgt_index;
        end else if (grant) begin
            text_addr_d  = host_addr;
            text_wdata_d = host_data;
            text_we_d    = ({1'b0, host_addr} < CELLS_W);
            host_ack_d   = 1'b1;
        end

        if (phase == 3'd2)
            font_addr_d = text_rdata;

        // Invalid targets (off-screen columns/lines) produce blank rows.
        if (phase == 3'd4)
            next_row_d = tgt_valid ? (glyph_slice ^ glyph_mask) : 8'h00;

        if (phase == 3'd7)
            shreg_d = next_row_q;
    end

    always_ff @(posedge clock25) begin
        if (reset) begin
            text_addr_q  <= '0;
            text_we_q    <= 1'b0;
            text_wdata_q <= '0;
            font_addr_q  <= '0;
            host_ack_q   <= 1'b0;
            pixel_q      <= 1'b0;
            shreg_q      <= '0;
            next_row_q   <= '0;
`ifdef CHARGEN_CURSOR_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            text_addr_q  <= text_addr_d;
            text_we_q    <= text_we_d;
            text_wdata_q <= text_wdata_d;
            font_addr_q  <= font_addr_d;
            host_ack_q   <= host_ack_d;
            pixel_q      <= pixel_d;
            shreg_q      <= shreg_d;
            next_row_q   <= next_row_d;
`ifdef CHARGEN_CURSOR_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign text_addr  = text_addr_q;
    assign text_we    = text_we_q;
    assign text_wdata = text_wdata_q;
    assign font_addr  = font_addr_q;
    assign host_ack   = host_ack_q;
    assign Pixel      = pixel_q;

endmodule

// File: tb/tb_text_fetch_sched.sv
module tb_text_fetch_sched;

    localparam int NREQ = 12;

    logic        clock25;
    logic        reset;
    logic [9:0]  HorizontalCounter;
    logic [9:0]  VerticalCounter;
    logic [11:0] text_addr;
    logic        text_we;
    logic [6:0]  text_wdata;
    logic [6:0]  text_rdata;
    logic [6:0]  font_addr;
    logic [95:0] font_data;
    logic        host_req;
    logic [11:0] host_addr;
    logic [6:0]  host_data;
    logic        host_ack;
    logic        Pixel;
`ifdef CHARGEN_CURSOR_EN
    logic [11:0] cursor_addr;
    assign cursor_addr = 12'hFFF;   // never matches a visible cell
`endif

    text_fetch_sched dut (
        .clock25(clock25), .reset(reset),
        .HorizontalCounter(HorizontalCounter), .VerticalCounter(VerticalCounter),
        .text_addr(text_addr), .text_we(text_we), .text_wdata(text_wdata),
        .text_rdata(text_rdata), .font_addr(font_addr), .font_data(font_data),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack),
`ifdef CHARGEN_CURSOR_EN
        .cursor_addr(cursor_addr),
`endif
        .Pixel(Pixel)
    );

    initial clock25 = 1'b0;
    always #5 clock25 = ~clock25;

    // Memories: ram is the physical text RAM (written only through the DUT);
    // ram_ref is the bench's expectation of what the RAM should hold.
    logic [6:0]  ram     [4096];
    logic [6:0]  ram_ref [4096];
    logic [95:0] rom     [128];
    logic        ram_init;

    always @(posedge clock25) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= ram_ref[i];
        end else if (text_we) begin
            ram[text_addr] <= text_wdata;
        end
        text_rdata <= ram[text_addr];
        font_data  <= rom[font_addr];
    end

    int nvec = 0;
    int nerr = 0;
    int cur_h, cur_v, warm;
    bit pix_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Screen-level reference: what a viewer should see at (x, y).
    function automatic logic exp_pix(input int x, input int y);
        logic [95:0] g;
        logic [7:0]  r;
        if (x >= 640 || y >= 480) return 1'b0;
        g = rom[int'(ram_ref[(y / 12) * 80 + x / 8])];
        r = g[95 - 8 * (y % 12) -: 8];
        return r[7 - (x % 8)];
    endfunction

    task automatic jump(input int h, input int v);
        cur_h = h;
        cur_v = v;
        warm  = 0;
    endtask

    // One clock with the current counters; pixel checked once the pipeline
    // has seen a full cell since the last jump (jumps land on cell starts).
    task automatic step();
        HorizontalCounter = 10'(cur_h);
        VerticalCounter   = 10'(cur_v);
        @(posedge clock25);
        #1;
        if (pix_chk && warm >= 8)
            chk("pixel", 32'(Pixel), 32'(exp_pix(cur_h, cur_v)));
        warm++;
        cur_h++;
        if (cur_h == 800) begin
            cur_h = 0;
            cur_v = (cur_v == 524) ? 0 : cur_v + 1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " text_addr"},  32'(text_addr),  32'd0);
        chk({tag, " text_we"},    32'(text_we),    32'd0);
        chk({tag, " text_wdata"}, 32'(text_wdata), 32'd0);
        chk({tag, " font_addr"},  32'(font_addr),  32'd0);
        chk({tag, " host_ack"},   32'(host_ack),   32'd0);
        chk({tag, " Pixel"},      32'(Pixel),      32'd0);
    endtask

    logic [11:0] qa [NREQ];
    logic [6:0]  qd [NREQ];

    initial begin
        automatic logic [7:0] pat = 8'hA5;
        automatic int idx, acks;
        automatic bit g, ack_prev, idle;
        automatic logic [11:0] a;
        automatic logic [6:0]  d;

        for (int i = 0; i < 4096; i++) ram_ref[i] = 7'($urandom);
        for (int i = 0; i < 128; i++) rom[i] = {$urandom, $urandom, $urandom};
        ram_ref[0] = 7'h41;
        rom[7'h41][95:88] = 8'hA5;

        host_req = 1'b0; host_addr = '0; host_data = '0;
        pix_chk = 1'b0;
        reset = 1'b1; ram_init = 1'b1;
        jump(300, 100);
        step();
        ram_init = 1'b0;
        step();
        chk_all_zero("reset");
        reset = 1'b0;

        // Cell 0 fetched at the end of line 524, displayed on line 0.
        jump(784, 524);
        repeat (8) step();
        step();
        chk("fetch addr at H=792", 32'(text_addr), 32'd0);
        repeat (7) step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("glyph 0xA5 pixel", 32'(Pixel), 32'(pat[7 - i]));
        end

        // Row/column mapping: V=13, H=16 fetches cell (1,3).
        jump(8, 13);
        repeat (8) step();
        step();
        chk("mapping text_addr", 32'(text_addr), 32'd83);
        pix_chk = 1'b1;
        repeat (24) step();

        // Random and boundary display spans.
        for (int s = 0; s < 6; s++) begin
            jump(8 * $urandom_range(0, 99), $urandom_range(0, 524));
            repeat (240) step();
        end
        jump(600, 479); repeat (300) step();
        jump(760, 524); repeat (100) step();
        jump(624, 200); repeat (200) step();
        jump(0, 500);   repeat (800) step();
        pix_chk = 1'b0;

        // Request sampled at p=0 waits for p=1; display read unaffected.
        jump(16, 0);
        host_req = 1'b1; host_addr = 12'd5; host_data = 7'h33;
        step();
        chk("p0 host_ack", 32'(host_ack), 32'd0);
        chk("p0 text_we", 32'(text_we), 32'd0);
        chk("p0 display addr", 32'(text_addr), 32'd3);
        step();
        chk("p1 host_ack", 32'(host_ack), 32'd1);
        chk("p1 text_we", 32'(text_we), 32'd1);
        chk("p1 text_addr", 32'(text_addr), 32'd5);
        chk("p1 text_wdata", 32'(text_wdata), 32'h33);
        host_req = 1'b0;
        step();
        chk("p2 font_addr", 32'(font_addr), 32'(ram_ref[3]));
        chk("p2 host_ack", 32'(host_ack), 32'd0);
        chk("p2 text_we", 32'(text_we), 32'd0);
        ram_ref[5] = 7'h33;
        step();
        chk("ram[5] written", 32'(ram[5]), 32'h33);

        // Out-of-range write: acked, dropped.
        jump(41, 0);
        host_req = 1'b1; host_addr = 12'd3200; host_data = 7'h11;
        step();
        chk("oor host_ack", 32'(host_ack), 32'd1);
        chk("oor text_we", 32'(text_we), 32'd0);
        host_req = 1'b0;
        step();
        chk("oor ack drop", 32'(host_ack), 32'd0);

        // Randomised host write stream against the arbitration rules.
        for (int i = 0; i < NREQ; i++) begin
            qa[i] = 12'($urandom_range(0, 3199));
            qd[i] = 7'($urandom);
        end
        qa[3] = 12'd3200;
        qa[7] = 12'd4095;
        jump(8 * $urandom_range(0, 99), $urandom_range(0, 524));
        idx = 0; acks = 0; ack_prev = 1'b0; idle = 1'b0;
        for (int c = 0; c < 120 && idx < NREQ; c++) begin
            a = qa[idx];
            d = qd[idx];
            host_req = !idle; host_addr = a; host_data = d;
            g = !idle && (cur_h % 8 != 0) && !ack_prev;
            step();
            chk("stream host_ack", 32'(host_ack), 32'(g));
            chk("stream text_we", 32'(text_we), 32'(g && a < 12'd3200));
            if (g) begin
                chk("stream text_addr", 32'(text_addr), 32'(a));
                chk("stream text_wdata", 32'(text_wdata), 32'(d));
                if (a < 12'd3200) ram_ref[a] = d;
            end
            ack_prev = g;
            idle = 1'b0;
            if (host_ack) begin
                idx++;
                acks++;
                idle = ($urandom_range(0, 1) == 1);
            end
        end
        host_req = 1'b0;
        chk("stream all served", 32'(acks), 32'(NREQ));
        step(); step();
        for (int i = 0; i < NREQ; i++)
            chk("stream ram contents", 32'(ram[qa[i]]), 32'(ram_ref[qa[i]]));

        // Reset mid-line with a held request: exactly one ack afterwards.
        jump(200, 100);
        repeat (5) step();
        host_req = 1'b1; host_addr = 12'd7; host_data = 7'h55;
        reset = 1'b1;
        step();
        chk_all_zero("mid reset");
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (host_ack) begin
                acks++;
                host_req = 1'b0;
            end
        end
        chk("post-reset ack count", 32'(acks), 32'd1);
        ram_ref[7] = 7'h55;
        chk("post-reset ram[7]", 32'(ram[7]), 32'h55);

        // Display after all host writes reflects the new RAM contents.
        pix_chk = 1'b1;
        jump(0, 0);  repeat (700) step();
        jump(0, 11); repeat (200) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "timeout");
    end

endmodule
